alu_m_unit: RTL
===============

# alu_m_unit

Parametrised execute-stage arithmetic unit for the 5-stage pipeline. It covers the base integer ALU operations, with encodings unchanged, and adds the RV32M multiply and divide family. Base operations complete in one cycle at full throughput. Multiply runs with a configurable latency, and divide/remainder runs on an iterative restoring divider. A valid/ready handshake with a writeback tag lets the hazard unit stall the pipeline while a long operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand and result width (≥ 8, power of two).
- MUL_LATENCY, 2, cycles from accept to result for MUL* ops (1..4).
- TAG_W, 5, width of the passthrough tag (destination register index).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept an operation this cycle.
- op_i  in  5  operation select, encodings below.
- operand_a_i  in  WIDTH  rs1 operand.
- operand_b_i  in  WIDTH  rs2 or immediate operand.
- tag_i  in  TAG_W  tag accepted with the operation.
- flush_i  in  1  abort any in-flight operation.
- valid_o  out  1  single-cycle pulse: result_o and tag_o are valid.
- result_o  out  WIDTH  registered result.
- tag_o  out  TAG_W  tag of the completing operation.

## Operation
- Accept occurs when valid_i & ready_o & ~flush_i at a rising edge. A request in any other cycle is ignored and not queued.
- Base op encodings:
  - 0x00 ADD, 0x01 SUB, 0x02 SLT (signed), 0x03 SLTU.
  - 0x04 XOR, 0x05 OR, 0x06 AND.
  - 0x07 SLL, 0x08 SRL, 0x09 SRA.
  - 0x0A PASS_B.
  - Shift amount is operand_b_i[$clog2(WIDTH)-1:0].
  - SLT/SLTU produce a 0/1 result zero-extended to WIDTH.
- M op encodings:
  - 0x10 MUL: low WIDTH bits of the product.
  - 0x11 MULH: signed×signed, high half.
  - 0x12 MULHSU: signed a × unsigned b, high half.
  - 0x13 MULHU: unsigned×unsigned, high half.
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
- Any other op value produces result 0 with base latency.
- Arithmetic wraps modulo 2^WIDTH.
- DIV/REM round toward zero. The remainder takes the sign of the dividend.
- Division special cases resolve on the fast path:
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = most-negative value; remainder 0.
- FSM states:
  - IDLE: base ops, unknown ops and div special cases register their result here and the unit stays in IDLE.
  - MUL_BUSY: counts MUL_LATENCY−1 cycles, then registers the result and returns to IDLE. Entered only when MUL_LATENCY > 1.
  - DIV_BUSY: normal divides iterate one quotient bit per cycle for WIDTH cycles, latch operand signs, apply sign correction on the final cycle, then return to IDLE.
- ready_o is 1 exactly when the state is IDLE.
- The tag is captured at accept and presented on tag_o together with valid_o.

## Timing
- Latency from an accept in cycle N to valid_o:
  - Base, unknown and div-special ops: N+1.
  - MUL*: N+MUL_LATENCY.
  - Normal DIV/REM: N+WIDTH+1.
- ready_o:
  - Low during cycles N+1 .. N+L−1.
  - High again in the cycle valid_o is asserted, so a new op may be accepted in that same cycle.
  - Base ops sustain one accept per cycle, with valid_o high on consecutive cycles.
- valid_o is high for exactly one cycle per accepted op. There is no back-pressure on the output; the pipeline must consume the result that cycle.
- result_o and tag_o hold their last value while valid_o is low.
- flush_i:
  - Forces IDLE at the next edge and suppresses valid_o in that next cycle.
  - Discards the in-flight operation, including one completing in the same edge.
  - Takes priority over a simultaneous valid_i, which is not accepted.
- rst_i, applied in any state including mid-divide:
  - Next cycle: state IDLE, valid_o 0, result_o 0, tag_o 0, counters 0.
  - ready_o 1 in the first cycle after reset deasserts.

## Test plan
- **Back-to-back ADD:** accept ADD 5+7 at N, then ADD 0xFFFFFFFF+1 at N+1. Required: valid_o at N+1 with 12, valid_o at N+2 with 0; ready_o stays 1; tags returned in order.
- **Compare and shift:** a=0xFFFFFFFF, b=1 gives SLT=1 and SLTU=0. SRA 0x80000000 by 4 gives 0xF8000000. SLL by 33 uses 1 as the shift amount.
- **Multiply, MUL_LATENCY=2:** a=b=0x80000000 gives MUL=0 and MULH=0x40000000. MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF gives 0xFFFFFFFF. Each result at N+2 with ready_o=0 at N+1.
- **Divide:** DIV −7/2 gives 0xFFFFFFFD; REM −7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14. Each valid at N+33, with ready_o low at N+1..N+32 and high at N+33.
- **Division special cases:** DIV 5/0 gives 0xFFFFFFFF; REMU 9/0 gives 9; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0. All results at N+1.
- **Abort paths:**
  - flush_i at N+10 of a DIV: no valid_o ever appears for it. An ADD 1+1 accepted at N+11 returns 2 at N+12.
  - rst_i at N+10 of a DIV: all outputs are 0 and ready_o is 1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/alu_m_unit.sv
// Execute-stage ALU with the RV32M multiply/divide family.
// Base ops take one cycle, multiplies take MUL_LATENCY cycles, and divides use an iterative restoring divider.
module alu_m_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_SLT    = 5'h02;
  localparam logic [4:0] OP_SLTU   = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_OR     = 5'h05;
  localparam logic [4:0] OP_AND    = 5'h06;
  localparam logic [4:0] OP_SLL    = 5'h07;
  localparam logic [4:0] OP_SRL    = 5'h08;
  localparam logic [4:0] OP_SRA    = 5'h09;
  localparam logic [4:0] OP_PASSB  = 5'h0A;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             valid_r;
  logic [WIDTH-1:0] result_r;
  logic [TAG_W-1:0] tag_r;
  logic [TAG_W-1:0] tag_pend_r;
  logic [WIDTH-1:0] mul_hold_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic             neg_res_r;
  logic             is_rem_r;

  logic [CNT_W-1:0]   shamt_s;
  logic [WIDTH-1:0]   base_res_s;
  logic               is_mul_s;
  logic               is_div_s;
  logic [2*WIDTH-1:0] mul_a_s;
  logic [2*WIDTH-1:0] mul_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   mul_res_s;
  logic               div_signed_s;
  logic               div_is_rem_s;
  logic               div_zero_s;
  logic               div_ovf_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [WIDTH-1:0]   div_spec_res_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     diff_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;
  logic [WIDTH-1:0]   div_mag_s;
  logic [WIDTH-1:0]   div_final_s;

  assign ready_o  = (state_r == ST_IDLE);
  assign valid_o  = valid_r;
  assign result_o = result_r;
  assign tag_o    = tag_r;
  assign shamt_s  = operand_b_i[CNT_W-1:0];

  // Single-cycle base operations; unknown encodings fall through to zero.
  always_comb begin
    base_res_s = ZERO_W;
    case (op_i)
      OP_ADD:   base_res_s = operand_a_i + operand_b_i;
      OP_SUB:   base_res_s = operand_a_i - operand_b_i;
      OP_SLT:   base_res_s = {{(WIDTH-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
      OP_SLTU:  base_res_s = {{(WIDTH-1){1'b0}}, (operand_a_i < operand_b_i)};
      OP_XOR:   base_res_s = operand_a_i ^ operand_b_i;
      OP_OR:    base_res_s = operand_a_i | operand_b_i;
      OP_AND:   base_res_s = operand_a_i & operand_b_i;
      OP_SLL:   base_res_s = operand_a_i << shamt_s;
      OP_SRL:   base_res_s = operand_a_i >> shamt_s;
      OP_SRA:   base_res_s = $unsigned($signed(operand_a_i) >>> shamt_s);
      OP_PASSB: base_res_s = operand_b_i;
      default:  base_res_s = ZERO_W;
    endcase
  end

  // Multiplier: operands extended to 2*WIDTH so one unsigned product serves every signedness mix.
  always_comb begin
    is_mul_s = (op_i[4:2] == 3'b100);
    is_div_s = (op_i[4:2] == 3'b101);
    mul_a_s  = {{WIDTH{(op_i != OP_MULHU) & operand_a_i[WIDTH-1]}}, operand_a_i};
    mul_b_s  = {{WIDTH{(op_i == OP_MULH) & operand_b_i[WIDTH-1]}}, operand_b_i};
    prod_s   = mul_a_s * mul_b_s;
    if (op_i == OP_MUL) begin
      mul_res_s = prod_s[WIDTH-1:0];
    end else begin
      mul_res_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Divider setup: operand magnitudes and the results of the two special cases.
  always_comb begin
    div_signed_s = ~op_i[0];
    div_is_rem_s = op_i[1];
    div_zero_s   = (operand_b_i == ZERO_W);
    div_ovf_s    = div_signed_s & (operand_a_i == MIN_W) & (operand_b_i == ONES_W);
    a_neg_s      = div_signed_s & operand_a_i[WIDTH-1];
    b_neg_s      = div_signed_s & operand_b_i[WIDTH-1];
    a_abs_s      = a_neg_s ? (ZERO_W - operand_a_i) : operand_a_i;
    b_abs_s      = b_neg_s ? (ZERO_W - operand_b_i) : operand_b_i;
    if (div_zero_s) begin
      div_spec_res_s = div_is_rem_s ? operand_a_i : ONES_W;
    end else begin
      div_spec_res_s = div_is_rem_s ? ZERO_W : MIN_W;
    end
  end

  // One restoring step per cycle; the sign fix-up is applied to the final step's output.
  always_comb begin
    shift_s     = {rem_r, quo_r[WIDTH-1]};
    diff_s      = shift_s - {1'b0, dvs_r};
    qbit_s      = ~diff_s[WIDTH];
    rem_nxt_s   = qbit_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
    quo_nxt_s   = {quo_r[WIDTH-2:0], qbit_s};
    div_mag_s   = is_rem_r ? rem_nxt_s : quo_nxt_s;
    div_final_s = neg_res_r ? (ZERO_W - div_mag_s) : div_mag_s;
  end

  // Control FSM and output registers; flush discards in-flight work but keeps the last result/tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      valid_r    <= 1'b0;
      result_r   <= ZERO_W;
      tag_r      <= '0;
      tag_pend_r <= '0;
      mul_hold_r <= ZERO_W;
      quo_r      <= ZERO_W;
      rem_r      <= ZERO_W;
      dvs_r      <= ZERO_W;
      neg_res_r  <= 1'b0;
      is_rem_r   <= 1'b0;
    end else if (flush_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_r <= 1'b0;
          if (valid_i) begin
            cnt_r <= '0;
            if (is_mul_s && (MUL_LATENCY > 1)) begin
              mul_hold_r <= mul_res_s;
              tag_pend_r <= tag_i;
              state_r    <= ST_MUL;
            end else if (is_mul_s) begin
              result_r <= mul_res_s;
              tag_r    <= tag_i;
              valid_r  <= 1'b1;
            end else if (is_div_s && !div_zero_s && !div_ovf_s) begin
              quo_r      <= a_abs_s;
              rem_r      <= ZERO_W;
              dvs_r      <= b_abs_s;
              neg_res_r  <= div_is_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
              is_rem_r   <= div_is_rem_s;
              tag_pend_r <= tag_i;
              state_r    <= ST_DIV;
            end else if (is_div_s) begin
              result_r <= div_spec_res_s;
              tag_r    <= tag_i;
              valid_r  <= 1'b1;
            end else begin
              result_r <= base_res_s;
              tag_r    <= tag_i;
              valid_r  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (cnt_r == CNT_W'(MUL_LATENCY - 2)) begin
            result_r <= mul_hold_r;
            tag_r    <= tag_pend_r;
            valid_r  <= 1'b1;
            cnt_r    <= '0;
            state_r  <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
            valid_r <= 1'b0;
          end
        end
        ST_DIV: begin
          quo_r <= quo_nxt_s;
          rem_r <= rem_nxt_s;
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            result_r <= div_final_s;
            tag_r    <= tag_pend_r;
            valid_r  <= 1'b1;
            cnt_r    <= '0;
            state_r  <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
